// File: rtl/usb_bus_pkg.sv
// usb_bus_pkg: shared constants for the parallel register bus initiator.
//   - bus / timer widths
//   - default strobe timings (cycles)
//   - FSM state encoding
//   - tmr_cyc(): converts a phase length in cycles to a timer load value
package usb_bus_pkg;

  localparam int BUS_W = 8;
  localparam int TMR_W = 8;

  localparam int DEF_SETUP  = 2;
  localparam int DEF_WR_LOW = 2;
  localparam int DEF_RD_LOW = 4;
  localparam int DEF_GAP    = 3;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ADDR  = 4'd1;
  localparam logic [3:0] S_ALREL = 4'd2;
  localparam logic [3:0] S_WAITW = 4'd3;
  localparam logic [3:0] S_WLOW  = 4'd4;
  localparam logic [3:0] S_WHOLD = 4'd5;
  localparam logic [3:0] S_RLOW  = 4'd6;
  localparam logic [3:0] S_RHIGH = 4'd7;
  localparam logic [3:0] S_GAP   = 4'd8;
  localparam logic [3:0] S_FIN   = 4'd9;

  // The timer is loaded on entry to a phase.
  // The phase ends on the cycle the timer reads zero, so the load value is (cycles - 1).
  function automatic logic [TMR_W-1:0] tmr_cyc(input int cycles);
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/usb_strobe_timer.sv
// usb_strobe_timer: loadable down-counter with a zero flag.
// It times the address setup phase, the strobe-low phases and the gap phase.
//   clk_usb, reset_n : clock, asynchronous active-low reset
//   load, load_val   : load the counter (has priority over counting)
//   zero             : counter is at zero (the counter holds at zero)
module usb_strobe_timer #(
  parameter int W = 8
) (
  input  logic         clk_usb,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n)          cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/usb_reg_master.sv
// usb_reg_master: bus initiator for the parallel register interface.
// It turns a command (addr, direction, len) into timed alen/cen/wrn/rdn strobe sequences.
//   cmd_*          : command request stream (accepted only in IDLE)
//   wr_*           : write byte stream; wr_ready marks the byte consumed this cycle
//   rd_data/valid  : one pulse per read byte, with no backpressure
//   busy, done     : burst status; done pulses once at the end of the burst
//   bus_*          : registered pins to the slave; bus_din is read back from the slave
module usb_reg_master
  import usb_bus_pkg::*;
#(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pSETUP        = DEF_SETUP,
  parameter int pWR_LOW       = DEF_WR_LOW,
  parameter int pRD_LOW       = DEF_RD_LOW,
  parameter int pGAP          = DEF_GAP
) (
  input  logic                     clk_usb,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [BUS_W-1:0]         cmd_addr,
  input  logic [pBYTECNT_SIZE-1:0] cmd_len,
  input  logic [BUS_W-1:0]         wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [BUS_W-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic [BUS_W-1:0]         bus_addr,
  output logic [BUS_W-1:0]         bus_dout,
  input  logic [BUS_W-1:0]         bus_din,
  output logic                     bus_drive,
  output logic                     bus_rdn,
  output logic                     bus_wrn,
  output logic                     bus_cen,
  output logic                     bus_alen
);

  if (pRD_LOW < 4) begin : g_bad_rd_low
    $error("usb_reg_master: pRD_LOW must be >= 4");
  end
  if (pGAP < 3) begin : g_bad_gap
    $error("usb_reg_master: pGAP must be >= 3");
  end
  if (pWR_LOW < 2) begin : g_bad_wr_low
    $error("usb_reg_master: pWR_LOW must be >= 2");
  end

  logic [3:0]               state, nstate;
  logic                     write_q;
  logic [pBYTECNT_SIZE-1:0] len_q, cnt_q, cnt_inc;
  logic                     tmr_load, tmr_zero;
  logic [TMR_W-1:0]         tmr_val;

  assign cnt_inc   = cnt_q + pBYTECNT_SIZE'(1);
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign wr_ready  = (state == S_WAITW) && wr_valid;

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (cmd_valid) nstate = S_ADDR;
      S_ADDR:  if (tmr_zero)  nstate = S_ALREL;
      S_ALREL: nstate = (len_q == '0) ? S_FIN : (write_q ? S_WAITW : S_RLOW);
      S_WAITW: if (wr_valid)  nstate = S_WLOW;
      S_WLOW:  if (tmr_zero)  nstate = S_WHOLD;
      S_WHOLD: nstate = S_GAP;
      S_RLOW:  if (tmr_zero)  nstate = S_RHIGH;
      S_RHIGH: nstate = S_GAP;
      S_GAP:   if (tmr_zero)
                 nstate = (cnt_inc == len_q) ? S_FIN : (write_q ? S_WAITW : S_RLOW);
      S_FIN:   nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Every state change reloads the timer.
  // Only the timed phases use the count.
  always_comb begin
    tmr_load = (nstate != state);
    case (nstate)
      S_ADDR:  tmr_val = tmr_cyc(pSETUP);
      S_WLOW:  tmr_val = tmr_cyc(pWR_LOW);
      S_RLOW:  tmr_val = tmr_cyc(pRD_LOW);
      S_GAP:   tmr_val = tmr_cyc(pGAP);
      default: tmr_val = '0;
    endcase
  end

  usb_strobe_timer #(.W(TMR_W)) u_tmr (
    .clk_usb  (clk_usb),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Pins are registered from nstate, so each pin changes on the same edge as the state.
  // Only one of wrn and rdn is decoded low in any given state.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      write_q   <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      bus_alen  <= 1'b1;
      bus_cen   <= 1'b1;
      bus_wrn   <= 1'b1;
      bus_rdn   <= 1'b1;
      bus_drive <= 1'b0;
      bus_addr  <= '0;
      bus_dout  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= nstate;
      bus_alen <= !(nstate == S_ADDR);
      bus_cen  <= !(nstate inside {S_WLOW, S_WHOLD, S_RLOW});
      bus_wrn  <= !(nstate == S_WLOW);
      bus_rdn  <= !(nstate == S_RLOW);
      rd_valid <= (nstate == S_RHIGH);
      done     <= (nstate == S_FIN);

      if (state == S_IDLE && cmd_valid) begin
        bus_addr <= cmd_addr;
        write_q  <= cmd_write;
        len_q    <= cmd_len;
        cnt_q    <= '0;
      end

      if (wr_ready) bus_dout <= wr_data;

      // Data stays driven from the first write strobe until the burst ends.
      // It is dropped before any read strobe.
      if (nstate == S_WLOW)                          bus_drive <= 1'b1;
      else if (nstate inside {S_RLOW, S_FIN, S_IDLE}) bus_drive <= 1'b0;

      if (state == S_RLOW && tmr_zero) rd_data <= bus_din;
      if (state == S_GAP && tmr_zero)  cnt_q   <= cnt_inc;
    end
  end

endmodule
